fp_post_process_pipe: RTL and testbench
=======================================

// Module: fp_post_process_pipe
// PURPOSE
//  Parametrised, pipelined FPU result post-processor: biases exponent, denormalises, rounds, packs IEEE-754 result, raises flags.
//  Sits between every FPU datapath (add/mul/div/sqrt) and the FPU result mux; serves any EXP_W/MAN_W format.
//  2-stage pipeline with valid/ready flow control; accepts one result per cycle when downstream is ready.
// PARAMETERS
//  EXP_W  8   stored exponent width; BIAS = 2**(EXP_W-1)-1
//  MAN_W  23  stored mantissa width (hidden bit excluded); FLEN = 1+EXP_W+MAN_W
// PORTS
//  clk         in   1          clock
//  reset       in   1          synchronous, active-high reset
//  clear       in   1          synchronous pipeline flush, same effect as reset
//  in_valid    in   1          input result valid
//  in_ready    out  1          stage 1 can accept
//  rm          in   3          rounding mode: RNE=000 RTZ=001 RDN=010 RUP=011 RMM=100
//  man         in   MAN_W+1    normalised mantissa incl. hidden bit
//  Exp         in   EXP_W+2    unbiased exponent, two's complement
//  sgn         in   1          sign
//  round_bit   in   1          first bit below man LSB
//  sticky_bit  in   1          OR of all lower bits
//  final_res   in   1          operands already packed (NaN/Inf/zero): bypass rounding
//  IV_in,DZ_in in   1 each     flags forwarded only when final_res=1
//  out_valid   out  1          result valid
//  out_ready   in   1          downstream accepts
//  float_out   out  FLEN       packed result
//  IV,DZ,OF,UF,IE out 1 each   exception flags, qualified by out_valid
// BEHAVIOUR
//  Reset/clear: both stage valids 0; float_out=0, all flags 0, out_valid=0; in_ready=1 next cycle. Any in-flight data is dropped.
//  Handshake: stage advances when !valid_s || ready_next; in_ready = !valid_s1 || (!valid_s2 || out_ready).
//  Transfers occur on in_valid&&in_ready / out_valid&&out_ready. Latency 2 cycles; order preserved; no bubble at full rate.
//  Outputs stay stable while out_valid && !out_ready.
//  Stage 1: eb = Exp + BIAS (EXP_W+2 bits). If eb<=0: offset = 1-eb, saturated to MAN_W+2; exp field = 0.
//   Right-shift {man,round_bit} by offset; shifted-out bits OR sticky_bit -> new sticky. Register tiny_eq=(eb==0), tiny_lt=(eb<0).
//  Stage 2 (non-final): round per rm; carry increments exponent. exp_r >= 2**EXP_W-1 -> OF=IE=1;
//   RTZ, RDN&+, RUP&- give max finite {sgn,1..10,1..1}; all other cases give {sgn,all-ones,0}.
//  Otherwise UF=IE=1 if inexact && (tiny_lt || (tiny_eq && !carry)); else IE=inexact.
//  final_res=1: float_out={sgn,Exp[EXP_W-1:0],man[MAN_W-1:0]}; IV/DZ from inputs; OF=UF=IE=0.
//  Non-final: IV=DZ=0.
//  rm values 101..111 are treated as RNE.
// CONFIGURATION
//  FPU_PP_FTZ_EN defined: adds input ftz (1b, sampled with in_valid).
//   When ftz=1 and the result is tiny after rounding (UF condition, or exact subnormal), output is {sgn,0}, UF=IE=1.
//  Not defined: no ftz port; subnormals are always produced per IEEE.
// STRUCTURE
//  fpu_pkg: rm enum (RNE..RMM), fflags struct {IV,DZ,OF,UF,IE}, bias/FLEN functions of EXP_W/MAN_W.
//  Sub-module fp_round #(MAN_W): combinational rounder (in, round, sticky, sgn, rm -> out, carry, inexact).
//  Stage 1 reuses the existing rshifter sticky-shift.
// TESTING (EXP_W=8, MAN_W=23)
//  1. Tie to even: Exp=0, man=0x800000, rb=1, sb=0, RNE -> 0x3F800000, IE=1, out_valid exactly 2 cycles after accept.
//  2. Overflow: Exp=128, man=0x800000, RNE -> 0x7F800000, OF=IE=1. Same input with RTZ -> 0x7F7FFFFF.
//  3. Subnormal exact: Exp=-127, man=0x800000 -> 0x00400000, UF=IE=0. Exp=-130, man=0x800001, RNE -> UF=IE=1.
//  4. Round into normal: Exp=-127, man=0xFFFFFF, rb=1, RNE -> 0x00800000, UF=0, IE=1.
//  5. Bypass: final_res=1, Exp=0xFF, man=0xC00000, IV_in=1 -> 0x7FC00000, IV=1, other flags 0.
//  6. Backpressure: stream 4 inputs with out_ready=0 -> in_ready=0 after 2 accepted.
//     Release out_ready -> all 4 emerge in order with stable outputs; clear mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding-mode encoding, exception-flag bundle and format helpers.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic iv;
    logic dz;
    logic of;
    logic uf;
    logic ie;
  } fflags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_flen(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/fp_round.sv
// fp_round: combinational mantissa rounder driven by guard/sticky bits and rounding mode.
module fp_round
  import fpu_pkg::*;
#(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0] mant,
  input  logic           round_bit,
  input  logic           sticky_bit,
  input  logic           sgn,
  input  logic [2:0]     rm,
  output logic [MAN_W:0] mant_rnd,
  output logic           carry,
  output logic           inexact
);

  logic inc;

  // Unlisted encodings fall into the default arm and round to nearest even.
  always_comb begin
    inexact = round_bit | sticky_bit;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = inexact & sgn;
      RM_RUP:  inc = inexact & ~sgn;
      RM_RMM:  inc = round_bit;
      default: inc = round_bit & (sticky_bit | mant[0]);
    endcase
    {carry, mant_rnd} = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, inc};
  end

endmodule

// File: rtl/fp_post_process_pipe.sv
// fp_post_process_pipe: two-stage FPU result post-processor (bias, denormalise, round, pack, flags).
// Optional flush-to-zero input `ftz` is present when FPU_PP_FTZ_EN is defined.
module fp_post_process_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           rm,
  input  logic [MAN_W:0]       man,
  input  logic [EXP_W+1:0]     Exp,
  input  logic                 sgn,
  input  logic                 round_bit,
  input  logic                 sticky_bit,
  input  logic                 final_res,
  input  logic                 IV_in,
  input  logic                 DZ_in,
`ifdef FPU_PP_FTZ_EN
  input  logic                 ftz,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] float_out,
  output logic                 IV,
  output logic                 DZ,
  output logic                 OF,
  output logic                 UF,
  output logic                 IE
);

  localparam int FLEN  = fp_flen(EXP_W, MAN_W);
  localparam int EW    = EXP_W + 3;
  localparam int SHW   = MAN_W + 2;
  localparam int OFF_W = $clog2(SHW + 1);
  localparam logic [EW-1:0] BIAS_W  = EW'(fp_bias(EXP_W));
  localparam logic [EW-1:0] SHW_W   = EW'(SHW);
  localparam logic [EW-1:0] EXP_MAX = EW'((2 ** EXP_W) - 1);

  logic v1, v2, ready2;

  logic [EW-1:0]    exp_ext, eb, off_full, exp_st;
  logic             tiny_eq, tiny_lt;
  logic [OFF_W-1:0] offset;
  logic [2*SHW-1:0] sh;
  logic [MAN_W:0]   man_st;
  logic             rb_st, sb_st;

  logic             sgn1, rb1, sb1, tiny_eq1, tiny_lt1, fin1, iv1, dz1;
  logic [MAN_W:0]   man1;
  logic [EW-1:0]    exp1;
  logic [2:0]       rm1;
`ifdef FPU_PP_FTZ_EN
  logic             ftz1;
`endif

  logic [MAN_W:0]   man_r;
  logic             rnd_carry, inexact, tiny1, ovf, uf_cond, maxfin;
  logic [EW-1:0]    exp_r;
  logic [FLEN-1:0]  res;
  fflags_t          flg, flags;

  assign ready2    = !v2 || out_ready;
  assign in_ready  = !v1 || ready2;
  assign out_valid = v2;

  // Stage 1: the exponent is widened by one bit so large positive inputs cannot wrap negative
  // after biasing; tiny results shift {man,round_bit} right and fold the lost bits into sticky.
  always_comb begin
    exp_ext  = {Exp[EXP_W+1], Exp};
    eb       = exp_ext + BIAS_W;
    tiny_lt  = eb[EW-1];
    tiny_eq  = (eb == '0);
    off_full = EW'(1) - eb;
    offset   = '0;
    if (tiny_lt || tiny_eq)
      offset = (off_full > SHW_W) ? OFF_W'(SHW) : off_full[OFF_W-1:0];
    sh     = {man, round_bit, {SHW{1'b0}}} >> offset;
    man_st = sh[2*SHW-1:SHW+1];
    rb_st  = sh[SHW];
    sb_st  = sticky_bit | (|sh[SHW-1:0]);
    exp_st = (tiny_lt || tiny_eq) ? '0 : eb;
    if (final_res) begin
      man_st = man;
      rb_st  = 1'b0;
      sb_st  = 1'b0;
      exp_st = exp_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear)
      v1 <= 1'b0;
    else if (in_ready)
      v1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      sgn1     <= sgn;
      man1     <= man_st;
      rb1      <= rb_st;
      sb1      <= sb_st;
      exp1     <= exp_st;
      tiny_eq1 <= tiny_eq && !final_res;
      tiny_lt1 <= tiny_lt && !final_res;
      rm1      <= rm;
      fin1     <= final_res;
      iv1      <= IV_in;
      dz1      <= DZ_in;
`ifdef FPU_PP_FTZ_EN
      ftz1     <= ftz;
`endif
    end
  end

  fp_round #(.MAN_W(MAN_W)) u_round (
    .mant       (man1),
    .round_bit  (rb1),
    .sticky_bit (sb1),
    .sgn        (sgn1),
    .rm         (rm1),
    .mant_rnd   (man_r),
    .carry      (rnd_carry),
    .inexact    (inexact)
  );

  // Stage 2: a subnormal that rounds up into the hidden bit becomes the smallest normal,
  // so its exponent field comes from the rounded hidden bit rather than the carry-out.
  always_comb begin
    tiny1   = tiny_eq1 || tiny_lt1;
    exp_r   = tiny1 ? {{(EW-1){1'b0}}, man_r[MAN_W]} : exp1 + {{(EW-1){1'b0}}, rnd_carry};
    ovf     = !tiny1 && (exp_r >= EXP_MAX);
    uf_cond = inexact && (tiny_lt1 || (tiny_eq1 && !man_r[MAN_W]));
    maxfin  = (rm1 == RM_RTZ) || ((rm1 == RM_RDN) && !sgn1) || ((rm1 == RM_RUP) && sgn1);
    res     = {sgn1, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
    flg     = '0;
    if (fin1) begin
      res    = {sgn1, exp1[EXP_W-1:0], man1[MAN_W-1:0]};
      flg.iv = iv1;
      flg.dz = dz1;
    end else if (ovf) begin
      flg.of = 1'b1;
      flg.ie = 1'b1;
      if (maxfin)
        res = {sgn1, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else
        res = {sgn1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      flg.uf = uf_cond;
      flg.ie = inexact;
`ifdef FPU_PP_FTZ_EN
      if (ftz1 && (uf_cond || (tiny1 && !man_r[MAN_W]))) begin
        res    = {sgn1, {(FLEN-1){1'b0}}};
        flg.uf = 1'b1;
        flg.ie = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      v2        <= 1'b0;
      float_out <= '0;
      flags     <= '0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        float_out <= res;
        flags     <= flg;
      end
    end
  end

  assign IV = flags.iv;
  assign DZ = flags.dz;
  assign OF = flags.of;
  assign UF = flags.uf;
  assign IE = flags.ie;

endmodule

// File: tb/tb_fp_post_process_pipe.sv
// Testbench for fp_post_process_pipe (EXP_W=8, MAN_W=23): vector table plus scoreboard queue.
module tb_fp_post_process_pipe;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  rm;
  logic [23:0] man;
  logic [9:0]  Exp;
  logic        sgn, round_bit, sticky_bit, final_res, IV_in, DZ_in;
  logic [31:0] float_out;
  logic        IV, DZ, OF, UF, IE;
`ifdef FPU_PP_FTZ_EN
  logic        ftz;
`endif

  always #5 clk = ~clk;

  fp_post_process_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rm         (rm),
    .man        (man),
    .Exp        (Exp),
    .sgn        (sgn),
    .round_bit  (round_bit),
    .sticky_bit (sticky_bit),
    .final_res  (final_res),
    .IV_in      (IV_in),
    .DZ_in      (DZ_in),
`ifdef FPU_PP_FTZ_EN
    .ftz        (ftz),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .float_out  (float_out),
    .IV         (IV),
    .DZ         (DZ),
    .OF         (OF),
    .UF         (UF),
    .IE         (IE)
  );

  typedef struct {
    int          id;
    logic [2:0]  rm;
    logic [9:0]  exp;
    logic [23:0] man;
    logic        sgn, rb, sb, fin, iv, dz;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t tbl[$];
  vec_t stim_q[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc_cnt = 0;

  function automatic vec_t mk(input logic [2:0] r, input logic [9:0] e, input logic [23:0] m,
                              input logic s, input logic rb, input logic sb, input logic fin,
                              input logic iv, input logic dz, input logic [31:0] res,
                              input logic [4:0] flg);
    vec_t v;
    v.id = tbl.size();
    v.rm = r; v.exp = e; v.man = m; v.sgn = s; v.rb = rb; v.sb = sb;
    v.fin = fin; v.iv = iv; v.dz = dz; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    stim_q.push_back(v);
  endtask

  task automatic checkOutput(input vec_t e);
    n_cmp++;
    if (float_out !== e.res || {IV, DZ, OF, UF, IE} !== e.flg) begin
      n_bad++;
      $display("[TB] FAIL vec%0d: got float_out=%h flags=%b, want %h %b",
               e.id, float_out, {IV, DZ, OF, UF, IE}, e.res, e.flg);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic waitIdle(input int budget, output int used);
    used = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0 || out_valid) && used < budget) begin
      @(posedge clk);
      #1;
      used++;
    end
    n_cmp++;
    if (used >= budget) begin
      n_bad++;
      $display("[TB] FAIL drain_timeout: got %0d items outstanding, want 0", exp_q.size() + stim_q.size());
    end
  endtask

  task automatic waitAccepts(input int base, input int count, input string name);
    int k;
    k = 0;
    while (acc_cnt - base < count && k < 40) begin
      @(posedge clk);
      #2;
      k++;
    end
    checkVal(name, 32'(acc_cnt - base), 32'(count));
  endtask

  // Driver: presents the head of the stimulus queue until it is accepted.
  initial begin
    in_valid = 1'b0; rm = '0; man = '0; Exp = '0; sgn = 1'b0;
    round_bit = 1'b0; sticky_bit = 1'b0; final_res = 1'b0; IV_in = 1'b0; DZ_in = 1'b0;
`ifdef FPU_PP_FTZ_EN
    ftz = 1'b0;
`endif
    forever begin
      @(posedge clk);
      #1;
      if (stim_q.size() > 0 && !reset) begin
        rm = stim_q[0].rm; Exp = stim_q[0].exp; man = stim_q[0].man; sgn = stim_q[0].sgn;
        round_bit = stim_q[0].rb; sticky_bit = stim_q[0].sb; final_res = stim_q[0].fin;
        IV_in = stim_q[0].iv; DZ_in = stim_q[0].dz;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  // Accept side: the expected result joins the scoreboard at the input handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !clear && in_valid && in_ready) begin
        exp_q.push_back(stim_q.pop_front());
        acc_cnt++;
      end
    end
  end

  // Output side: every completed output handshake pops and compares the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !clear && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_output: got float_out=%h with empty scoreboard, want no output", float_out);
        end else begin
          checkOutput(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0;
    int used;
    reset = 1'b1;
    clear = 1'b0;
    out_ready = 1'b1;

    //             rm      Exp     man        s  rb sb fin iv dz  result        {IV,DZ,OF,UF,IE}
    tbl.push_back(mk(RM_RNE, 10'h000, 24'h800000, 0, 1, 0, 0, 0, 0, 32'h3F800000, 5'b00001));
    tbl.push_back(mk(RM_RNE, 10'h080, 24'h800000, 0, 0, 0, 0, 0, 0, 32'h7F800000, 5'b00101));
    tbl.push_back(mk(RM_RTZ, 10'h080, 24'h800000, 0, 0, 0, 0, 0, 0, 32'h7F7FFFFF, 5'b00101));
    tbl.push_back(mk(RM_RNE, 10'h381, 24'h800000, 0, 0, 0, 0, 0, 0, 32'h00400000, 5'b00000));
    tbl.push_back(mk(RM_RNE, 10'h37E, 24'h800001, 0, 0, 0, 0, 0, 0, 32'h00080000, 5'b00011));
    tbl.push_back(mk(RM_RNE, 10'h381, 24'hFFFFFF, 0, 1, 0, 0, 0, 0, 32'h00800000, 5'b00001));
    tbl.push_back(mk(RM_RNE, 10'h0FF, 24'hC00000, 0, 0, 0, 1, 1, 0, 32'h7FC00000, 5'b10000));
    tbl.push_back(mk(RM_RUP, 10'h000, 24'h800000, 0, 0, 1, 0, 0, 0, 32'h3F800001, 5'b00001));
    tbl.push_back(mk(RM_RDN, 10'h000, 24'h800000, 0, 0, 1, 0, 0, 0, 32'h3F800000, 5'b00001));
    tbl.push_back(mk(RM_RDN, 10'h000, 24'h800000, 1, 1, 0, 0, 0, 0, 32'hBF800001, 5'b00001));
    tbl.push_back(mk(RM_RMM, 10'h000, 24'h800000, 0, 1, 0, 0, 0, 0, 32'h3F800001, 5'b00001));
    tbl.push_back(mk(RM_RNE, 10'h000, 24'hFFFFFF, 0, 1, 0, 0, 0, 0, 32'h40000000, 5'b00001));
    tbl.push_back(mk(RM_RNE, 10'h07F, 24'hFFFFFF, 0, 1, 0, 0, 0, 0, 32'h7F800000, 5'b00101));
    tbl.push_back(mk(RM_RUP, 10'h07F, 24'hFFFFFF, 1, 1, 0, 0, 0, 0, 32'hFF7FFFFF, 5'b00001));
    tbl.push_back(mk(RM_RUP, 10'h080, 24'h800000, 1, 0, 0, 0, 0, 0, 32'hFF7FFFFF, 5'b00101));
    tbl.push_back(mk(RM_RDN, 10'h080, 24'h800000, 1, 0, 0, 0, 0, 0, 32'hFF800000, 5'b00101));
    tbl.push_back(mk(3'b101, 10'h000, 24'h800000, 0, 1, 0, 0, 0, 0, 32'h3F800000, 5'b00001));
    tbl.push_back(mk(RM_RNE, 10'h0FF, 24'h800000, 1, 0, 0, 1, 0, 1, 32'hFF800000, 5'b01000));
    tbl.push_back(mk(RM_RNE, 10'h001, 24'hA00000, 0, 0, 0, 0, 0, 0, 32'h40200000, 5'b00000));
    tbl.push_back(mk(RM_RUP, 10'h2D4, 24'h800000, 0, 0, 0, 0, 0, 0, 32'h00000001, 5'b00011));
    tbl.push_back(mk(RM_RNE, 10'h000, 24'h800000, 0, 0, 0, 0, 1, 1, 32'h3F800000, 5'b00000));
    tbl.push_back(mk(RM_RNE, 10'h381, 24'h800001, 0, 0, 0, 0, 0, 0, 32'h00400000, 5'b00011));

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_out_valid", {31'b0, out_valid}, 32'h0);
    checkVal("rst_float_out", float_out, 32'h0);
    checkVal("rst_flags", {27'b0, IV, DZ, OF, UF, IE}, 32'h0);
    checkVal("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] latency check");
    acc0 = acc_cnt;
    applyStimulus(tbl[0]);
    waitAccepts(acc0, 1, "lat_accept");
    @(negedge clk);
    checkVal("lat_after_1_edge", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    checkVal("lat_after_2_edges", {31'b0, out_valid}, 32'h1);
    waitIdle(50, used);

    $display("[TB] vector table at full rate");
    for (int i = 1; i < tbl.size(); i++) applyStimulus(tbl[i]);
    waitIdle(300, used);
    checkVal("full_rate_cycles_ok", {31'b0, (used <= tbl.size() + 6)}, 32'h1);

    $display("[TB] backpressure");
    @(posedge clk);
    #1 out_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 11; i < 15; i++) applyStimulus(tbl[i]);
    waitAccepts(acc0, 2, "bp_two_accepted");
    @(negedge clk);
    checkVal("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal("bp_hold_valid", {31'b0, out_valid}, 32'h1);
      checkVal("bp_accept_count", 32'(acc_cnt - acc0), 32'd2);
      if (exp_q.size() > 0) checkVal("bp_hold_data", float_out, exp_q[0].res);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    waitIdle(60, used);

    $display("[TB] clear mid-stream");
    @(posedge clk);
    #1 out_ready = 1'b0;
    acc0 = acc_cnt;
    applyStimulus(tbl[0]);
    applyStimulus(tbl[7]);
    waitAccepts(acc0, 2, "clr_two_accepted");
    @(negedge clk);
    checkVal("clr_pre_valid", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    checkVal("clr_out_valid", {31'b0, out_valid}, 32'h0);
    checkVal("clr_float_out", float_out, 32'h0);
    checkVal("clr_in_ready", {31'b0, in_ready}, 32'h1);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkVal("clr_stays_empty", {31'b0, out_valid}, 32'h0);
    end
    applyStimulus(tbl[9]);
    waitIdle(50, used);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
